// File: rtl/usb_rx_phy.sv
// Low-speed USB receive front end: line synchroniser, counter DPLL, NRZI decode,
// SYNC/EOP detection, bit unstuffing and LSB-first byte assembly for the SIE.
module usb_rx_phy #(
  parameter int CLKS_PER_BIT = 16,
  parameter int RESET_CLKS   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] d_i,
  output logic [1:0] line_state,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_error,
  output logic       usb_reset,
  output logic [2:0] state_dbg
);

  // Interface semantics: rx_valid, rx_eop and rx_error are single-cycle pulses with no
  // backpressure; the SIE must take rx_data in the cycle rx_valid is high. rx_active is a level.

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int RST_W = $clog2(RESET_CLKS + 1);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [RST_W-1:0] RST_MAX  = RST_W'(RESET_CLKS);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_EOP  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  logic [1:0]       d_meta;
  logic [1:0]       ls_prev;
  logic             j_to_k;
  logic             jk_edge;
  logic [CNT_W-1:0] phase;
  logic             sample;
  logic [RST_W-1:0] se0_cnt;

  state_t           state, state_n;
  logic [1:0]       prev_lvl, prev_n;
  logic [7:0]       shreg, shreg_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [2:0]       ones_cnt, ones_n;
  logic [CNT_W-1:0] j_cnt, j_cnt_n;
  logic [7:0]       data_n;
  logic             valid_n, eop_n, error_n, active_n;
  logic             nrzi_bit;

  // Two-stage synchroniser; ls_prev is one more stage used only for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_meta     <= LS_J;
      line_state <= LS_J;
      ls_prev    <= LS_J;
    end else begin
      d_meta     <= d_i;
      line_state <= d_meta;
      ls_prev    <= line_state;
    end
  end

  assign j_to_k  = (ls_prev == LS_J) && (line_state == LS_K);
  assign jk_edge = j_to_k || ((ls_prev == LS_K) && (line_state == LS_J));

  // DPLL: every J/K transition realigns the phase, so the sample lands mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (jk_edge || (phase == LAST_CNT)) begin
      phase <= '0;
    end else begin
      phase <= phase + CNT_W'(1);
    end
  end

  assign sample = (phase == MID_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      se0_cnt <= '0;
    end else if (line_state == LS_SE0) begin
      if (se0_cnt != RST_MAX) se0_cnt <= se0_cnt + RST_W'(1);
    end else begin
      se0_cnt <= '0;
    end
  end

  assign usb_reset = (se0_cnt == RST_MAX);

  always_comb begin
    state_n   = state;
    prev_n    = prev_lvl;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    ones_n    = ones_cnt;
    j_cnt_n   = '0;
    data_n    = rx_data;
    valid_n   = 1'b0;
    eop_n     = 1'b0;
    error_n   = 1'b0;
    nrzi_bit  = (line_state == prev_lvl);

    unique case (state)
      ST_IDLE: begin
        prev_n    = LS_J;
        bit_cnt_n = '0;
        ones_n    = '0;
        if (j_to_k) state_n = ST_SYNC;
      end

      ST_SYNC: begin
        if (sample) begin
          if ((line_state == LS_SE0) || (line_state == LS_SE1)) begin
            state_n = ST_IDLE;
          end else begin
            prev_n = line_state;
            // The trailing K,K of SYNC is the only legal decoded 1 here.
            if (nrzi_bit) state_n = (line_state == LS_K) ? ST_DATA : ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (sample) begin
          if (line_state == LS_SE0) begin
            state_n = ST_EOP;
          end else if (line_state == LS_SE1) begin
            state_n = ST_ERR;
            error_n = 1'b1;
          end else begin
            prev_n = line_state;
            if (ones_cnt == 3'd6) begin
              // Stuff position: a 0 is dropped, a 1 is a stuff error.
              ones_n = '0;
              if (nrzi_bit) begin
                state_n = ST_ERR;
                error_n = 1'b1;
              end
            end else begin
              ones_n    = nrzi_bit ? (ones_cnt + 3'd1) : 3'd0;
              shreg_n   = {nrzi_bit, shreg[7:1]};
              bit_cnt_n = bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                data_n  = shreg_n;
                valid_n = 1'b1;
              end
            end
          end
        end
      end

      ST_EOP: begin
        ones_n = '0;
        // SE0 lasts two bit times, so further SE0 samples keep waiting for the J.
        if (sample) begin
          if (line_state == LS_J) begin
            state_n = ST_IDLE;
            if (bit_cnt == 3'd0) eop_n   = 1'b1;
            else                 error_n = 1'b1;
          end else if (line_state != LS_SE0) begin
            state_n = ST_ERR;
            error_n = 1'b1;
          end
        end
      end

      ST_ERR: begin
        ones_n    = '0;
        bit_cnt_n = '0;
        if (line_state == LS_J) begin
          if (j_cnt == LAST_CNT) state_n = ST_IDLE;
          else                   j_cnt_n = j_cnt + CNT_W'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (usb_reset) begin
      state_n = ST_IDLE;
      valid_n = 1'b0;
      eop_n   = 1'b0;
      error_n = 1'b0;
    end

    active_n = (state_n == ST_DATA) || (state_n == ST_EOP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      prev_lvl  <= LS_J;
      shreg     <= '0;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      j_cnt     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_eop    <= 1'b0;
      rx_error  <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      state     <= state_n;
      prev_lvl  <= prev_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      ones_cnt  <= ones_n;
      j_cnt     <= j_cnt_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      rx_eop    <= eop_n;
      rx_error  <= error_n;
      rx_active <= active_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Directed bench for usb_rx_phy: drives NRZI-encoded low-speed packets on d_i and
// checks strobes, received bytes, EOP/error handling and bus reset detection.
module tb_usb_rx_phy;

  localparam int CPB = 16;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] d_i;
  logic [1:0] line_state;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_error;
  logic       usb_reset;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  usb_rx_phy #(.CLKS_PER_BIT(CPB), .RESET_CLKS(60)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_i        (d_i),
    .line_state (line_state),
    .rx_active  (rx_active),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_eop     (rx_eop),
    .rx_error   (rx_error),
    .usb_reset  (usb_reset),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: monitor records strobes, the stimulus thread compares against exp_q.
  logic [7:0] exp_q[$];
  logic [7:0] got_mem [0:63];
  int valid_cnt = 0, eop_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  int v0, e0, r0;

  always @(negedge clk) begin
    if (rx_valid) begin
      got_mem[valid_cnt % 64] = rx_data;
      valid_cnt++;
    end
    if (rx_eop) eop_cnt++;
    if (rx_error) err_cnt++;
    if ((rx_eop && rx_error) || (rx_valid && (rx_eop || rx_error))) overlap_cnt++;
  end

  logic [1:0] cur;
  int         period;
  int         ones_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [1:0] lvl, input int n);
    d_i = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic nrzi(input logic b);
    if (!b) cur = (cur == J) ? K : J;
    hold(cur, period);
  endtask

  task automatic send_sync();
    cur      = J;
    ones_run = 0;
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    nrzi(1'b1);
  endtask

  task automatic send_data_bit(input logic b, input logic bad_stuff);
    nrzi(b);
    ones_run = b ? ones_run + 1 : 0;
    if (ones_run == 6) begin
      nrzi(bad_stuff);
      ones_run = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] value, input logic bad_stuff);
    for (int i = 0; i < 8; i++) send_data_bit(value[i], bad_stuff);
  endtask

  task automatic send_eop();
    hold(SE0, 2 * period);
    hold(J, period);
    cur = J;
  endtask

  task automatic snap();
    v0 = valid_cnt;
    e0 = eop_cnt;
    r0 = err_cnt;
  endtask

  task automatic check_packet(input string tag, input int exp_eop, input int exp_err);
    int n;
    n = exp_q.size();
    chk({tag, "_nvalid"}, 32'(valid_cnt - v0), 32'(n));
    for (int i = 0; i < n; i++)
      chk({tag, "_byte"}, 32'(got_mem[(v0 + i) % 64]), 32'(exp_q.pop_front()));
    chk({tag, "_eop"}, 32'(eop_cnt - e0), 32'(exp_eop));
    chk({tag, "_err"}, 32'(err_cnt - r0), 32'(exp_err));
  endtask

  initial begin
    reset  = 1'b1;
    d_i    = J;
    cur    = J;
    period = CPB;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_line_state", 32'(line_state), 32'(J));
    chk("rst_rx_active", 32'(rx_active), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_eop", 32'(rx_eop), 32'd0);
    chk("rst_rx_error", 32'(rx_error), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_usb_reset", 32'(usb_reset), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;

    // Idle J
    snap();
    hold(J, 100);
    chk("idle_line_state", 32'(line_state), 32'(J));
    chk("idle_rx_active", 32'(rx_active), 32'd0);
    check_packet("idle", 0, 0);

    // SYNC + 0xC3 + EOP at nominal rate
    snap();
    cur      = J;
    ones_run = 0;
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    chk("sync7_rx_active", 32'(rx_active), 32'd0);
    nrzi(1'b1);
    chk("sync8_rx_active", 32'(rx_active), 32'd1);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b0);
    send_eop();
    hold(J, 20);
    check_packet("c3", 1, 0);
    chk("c3_active_low", 32'(rx_active), 32'd0);

    // 0xFF with a correct stuff bit
    snap();
    send_sync();
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b0);
    send_eop();
    hold(J, 20);
    check_packet("ff_stuffed", 1, 0);

    // 0xFF with the stuff bit replaced by a 1
    snap();
    send_sync();
    send_byte(8'hFF, 1'b1);
    send_eop();
    hold(J, 30);
    check_packet("ff_bad_stuff", 0, 1);
    chk("bad_stuff_active", 32'(rx_active), 32'd0);

    // Four-byte packet at -6% and +6% bit period
    for (int p = 15; p <= 17; p += 2) begin
      period = p;
      snap();
      hold(J, 20);
      send_sync();
      exp_q.push_back(8'h2D);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h10);
      exp_q.push_back(8'hA5);
      send_byte(8'h2D, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'hA5, 1'b0);
      send_eop();
      hold(J, 30);
      check_packet((p == 15) ? "drift15" : "drift17", 1, 0);
    end
    period = CPB;

    // EOP after only five data bits
    snap();
    send_sync();
    send_data_bit(1'b1, 1'b0);
    send_data_bit(1'b0, 1'b0);
    send_data_bit(1'b1, 1'b0);
    send_data_bit(1'b0, 1'b0);
    send_data_bit(1'b0, 1'b0);
    send_eop();
    hold(J, 30);
    check_packet("short_eop", 0, 1);
    chk("short_eop_active", 32'(rx_active), 32'd0);

    // SE0 bus reset: line_state lags d_i by two cycles, then 60 SE0 cycles
    hold(SE0, 61);
    chk("usb_reset_early", 32'(usb_reset), 32'd0);
    hold(SE0, 1);
    chk("usb_reset_set", 32'(usb_reset), 32'd1);
    hold(SE0, 20);
    chk("usb_reset_held", 32'(usb_reset), 32'd1);
    chk("usb_reset_idle", 32'(state_dbg), 32'd0);
    hold(J, 2);
    chk("usb_reset_linger", 32'(usb_reset), 32'd1);
    chk("usb_reset_line_j", 32'(line_state), 32'(J));
    hold(J, 1);
    chk("usb_reset_clear", 32'(usb_reset), 32'd0);

    // Asynchronous reset mid-byte
    hold(J, 40);
    snap();
    send_sync();
    send_data_bit(1'b1, 1'b0);
    send_data_bit(1'b0, 1'b0);
    send_data_bit(1'b1, 1'b0);
    send_data_bit(1'b1, 1'b0);
    chk("mid_active", 32'(rx_active), 32'd1);
    chk("mid_data_hold", 32'(rx_data), 32'hA5);
    reset = 1'b1;
    #1;
    chk("arst_line_state", 32'(line_state), 32'(J));
    chk("arst_rx_active", 32'(rx_active), 32'd0);
    chk("arst_rx_data", 32'(rx_data), 32'd0);
    chk("arst_rx_valid", 32'(rx_valid), 32'd0);
    chk("arst_rx_eop", 32'(rx_eop), 32'd0);
    chk("arst_rx_error", 32'(rx_error), 32'd0);
    chk("arst_usb_reset", 32'(usb_reset), 32'd0);
    d_i = J;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hold(J, 40);
    check_packet("arst_quiet", 0, 0);

    // Reception restarts cleanly from IDLE
    snap();
    send_sync();
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b0);
    send_eop();
    hold(J, 20);
    check_packet("restart", 1, 0);

    chk("no_strobe_overlap", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
